// File: rtl/pe_rf_mp.sv
// PE register file: two write ports, N read ports, optional bypass and
// registered read, plus a bulk-clear sequencer that zeroes entries 2..Depth-1.
// Entry 0 reads zero and entry 1 reads the PE ID; writes to either are dropped.

// Per-read-port selection: hardwired entries, then bypass (port 1 priority),
// then stored contents.
module pe_rf_mp_rd_lane #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter logic [DW-1:0] PE_ID = '0
) (
  input  logic [AW-1:0]            rd_addr,
  input  logic [DEPTH-1:0][DW-1:0] mem,
  input  logic                     byp0_act,
  input  logic [AW-1:0]            wr0_addr,
  input  logic [DW-1:0]            wr0_data,
  input  logic                     byp1_act,
  input  logic [AW-1:0]            wr1_addr,
  input  logic [DW-1:0]            wr1_data,
  output logic [DW-1:0]            rd_data
);

  // Later assignments win: port 1 bypass overrides port 0, fixed entries override all.
  always_comb begin
    rd_data = mem[rd_addr];
    if (byp0_act && (wr0_addr == rd_addr)) rd_data = wr0_data;
    if (byp1_act && (wr1_addr == rd_addr)) rd_data = wr1_data;
    if (rd_addr == AW'(0)) rd_data = '0;
    if (rd_addr == AW'(1)) rd_data = PE_ID;
  end

endmodule

module pe_rf_mp #(
  parameter logic [31:0] Para_PE_ID      = 32'h0,
  parameter int          Para_Data_Width = 32,
  parameter int          Para_Depth      = 32,
  parameter int          Para_Num_Rd     = 2,
  parameter int          Para_Rd_Reg     = 0,
  parameter int          Para_Bypass     = 1,
  localparam int         AW              = $clog2(Para_Depth),
  localparam int         DW              = Para_Data_Width
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic [Para_Num_Rd*AW-1:0] iRd_Addr,
  output logic [Para_Num_Rd*DW-1:0] oRd_Data,
  input  logic                      iWr0_En,
  input  logic [AW-1:0]             iWr0_Addr,
  input  logic [DW-1:0]             iWr0_Data,
  input  logic                      iWr1_En,
  input  logic [AW-1:0]             iWr1_Addr,
  input  logic [DW-1:0]             iWr1_Data,
  input  logic                      iClr_Req,
  output logic                      oClr_Busy,
  output logic                      oClr_Done,
  output logic                      oWr_Ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic          BYPASS = (Para_Bypass != 0);
  localparam logic [DW-1:0] PE_ID  = DW'(Para_PE_ID);

  logic [1:0]                       state_q, state_d;
  logic [AW-1:0]                    ptr_q, ptr_d;
  logic [Para_Depth-1:0][DW-1:0]    mem_q, mem_d;
  logic [Para_Num_Rd-1:0][AW-1:0]   rd_addr;
  logic [Para_Num_Rd-1:0][DW-1:0]   rd_sel;
  logic                             wr_ready, wr0_act, wr1_act;

  // Writes are only accepted outside CLEAR and only to writable entries (>= 2).
  assign wr_ready = (state_q != ST_CLEAR);
  assign wr0_act  = iWr0_En & wr_ready & (iWr0_Addr[AW-1:1] != '0);
  assign wr1_act  = iWr1_En & wr_ready & (iWr1_Addr[AW-1:1] != '0);

  assign oClr_Busy = (state_q == ST_CLEAR);
  assign oClr_Done = (state_q == ST_DONE);
  assign oWr_Ready = wr_ready;

  // Clear sequencer: walk pointer from 2 to Depth-1, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (iClr_Req) begin
          state_d = ST_CLEAR;
          ptr_d   = AW'(2);
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(Para_Depth - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage update: port 1 applied after port 0 so it wins on address collision;
  // clear and writes are mutually exclusive since writes are gated during CLEAR.
  always_comb begin
    mem_d = mem_q;
    if (wr0_act) mem_d[iWr0_Addr] = iWr0_Data;
    if (wr1_act) mem_d[iWr1_Addr] = iWr1_Data;
    if (state_q == ST_CLEAR) mem_d[ptr_q] = '0;
  end

  // State, pointer and storage flops; reset zeroes everything and aborts a clear.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  assign rd_addr = iRd_Addr;

  for (genvar k = 0; k < Para_Num_Rd; k++) begin : g_lane
    pe_rf_mp_rd_lane #(
      .DW    (DW),
      .DEPTH (Para_Depth),
      .AW    (AW),
      .PE_ID (PE_ID)
    ) u_lane (
      .rd_addr  (rd_addr[k]),
      .mem      (mem_q),
      .byp0_act (wr0_act & BYPASS),
      .wr0_addr (iWr0_Addr),
      .wr0_data (iWr0_Data),
      .byp1_act (wr1_act & BYPASS),
      .wr1_addr (iWr1_Addr),
      .wr1_data (iWr1_Data),
      .rd_data  (rd_sel[k])
    );
  end

  if (Para_Rd_Reg != 0) begin : g_rd_reg
    logic [Para_Num_Rd-1:0][DW-1:0] rd_q, rd_d;
    assign rd_d = rd_sel;
    // Registered read: selection captured at the edge, visible one cycle later.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) rd_q <= '0;
      else         rd_q <= rd_d;
    end
    assign oRd_Data = rd_q;
  end else begin : g_rd_comb
    assign oRd_Data = rd_sel;
  end

endmodule
